// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor resolution path.
// One pipeline entry is {valid, bp, pc}.
package bp_pkg;

  typedef struct packed {
    logic        valid;
    logic        bp;
    logic [31:0] pc;
  } bp_stage_t;

  localparam logic [31:0] PC_INC = 32'd4;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/bp_pipe_stage.sv
// One prediction-carrying pipeline register.
// Priority: reset > kill > flush > stall > advance.
module bp_pipe_stage
  import bp_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      stall,
  input  logic      flush,
  input  logic      kill,
  input  logic      prev_adv,
  input  bp_stage_t d,
  output bp_stage_t q
);

  bp_stage_t r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (kill) begin
      r_q.valid <= 1'b0;
    end else if (flush) begin
      r_q.valid <= 1'b0;
    end else if (!stall) begin
      // older stage held back: take a bubble, not a duplicate
      if (prev_adv) r_q <= d;
      else          r_q.valid <= 1'b0;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/bp_resolve_unit.sv
// Carries fetch predictions to the branch stage, resolves them,
// redirects fetch on a miss and counts branches/mispredicts.
module bp_resolve_unit
  import bp_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             BPF,
  input  logic [31:0]      PCF,
  input  logic             ValidF,
  input  logic [DEPTH-1:0] StallV,
  input  logic [DEPTH-1:0] FlushV,
  input  logic             BranchB,
  input  logic             ZeroB,
  input  logic [31:0]      PCTargetB,
  output logic [31:0]      PCB,
  output logic             BranchUpdB,
  output logic             TakenB,
  output logic             MispredictB,
  output logic [31:0]      RedirectPC,
  output logic [CNT_W-1:0] BranchCnt,
  output logic [CNT_W-1:0] MissCnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  bp_stage_t [DEPTH-1:0] w_d;
  bp_stage_t [DEPTH-1:0] w_q;
  logic      [DEPTH-1:0] w_prev_adv;
  bp_stage_t             w_b;
  logic                  w_fire;
  logic                  w_mis;
  logic                  w_upd;
  logic [CNT_W-1:0]      r_bcnt;
  logic [CNT_W-1:0]      r_mcnt;

  assign w_d[0]        = bp_stage_t'({ValidF, BPF, PCF});
  assign w_prev_adv[0] = 1'b1;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k > 0) begin : g_link
      assign w_d[k]        = w_q[k-1];
      assign w_prev_adv[k] = ~StallV[k-1];
    end
    bp_pipe_stage u_stage (
      .clk      (clk),
      .reset    (reset),
      .stall    (StallV[k]),
      .flush    (FlushV[k]),
      .kill     (w_mis),
      .prev_adv (w_prev_adv[k]),
      .d        (w_d[k]),
      .q        (w_q[k])
    );
  end

  assign w_b    = w_q[DEPTH-1];
  assign w_fire = w_b.valid & ~StallV[DEPTH-1];
  assign w_upd  = w_fire & BranchB;
  // a non-branch that was predicted taken sent fetch down a bogus path
  assign w_mis  = w_fire & ((BranchB & (w_b.bp != ZeroB))
                          | (~BranchB & w_b.bp));

  assign PCB         = w_b.pc;
  assign BranchUpdB  = w_upd;
  assign TakenB      = ZeroB & w_upd;
  assign MispredictB = w_mis;

  always_comb begin
    RedirectPC = 32'd0;
    if (w_mis) begin
      if (BranchB && ZeroB) RedirectPC = PCTargetB;
      else                  RedirectPC = next_pc(w_b.pc);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bcnt <= '0;
      r_mcnt <= '0;
    end else begin
      if (w_upd && r_bcnt != CNT_MAX) r_bcnt <= r_bcnt + CNT_ONE;
      if (w_mis && r_mcnt != CNT_MAX) r_mcnt <= r_mcnt + CNT_ONE;
    end
  end

  assign BranchCnt = r_bcnt;
  assign MissCnt   = r_mcnt;

endmodule

// File: tb/tb_bp_resolve_unit.sv
// Scoreboard bench for bp_resolve_unit (CNT_W=16 and a CNT_W=2 twin).
// Expected outcomes are queued at fetch and popped at resolution.
module tb_bp_resolve_unit;
  import bp_pkg::*;

  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             BPF, ValidF, BranchB, ZeroB;
  logic [31:0]      PCF, PCTargetB;
  logic [DEPTH-1:0] StallV, FlushV;

  logic [31:0] PCB, RedirectPC, s_PCB, s_RedirectPC;
  logic        BranchUpdB, TakenB, MispredictB;
  logic        s_BranchUpdB, s_TakenB, s_MispredictB;
  logic [15:0] BranchCnt, MissCnt;
  logic [1:0]  s_BranchCnt, s_MissCnt;

  bp_resolve_unit #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .BPF(BPF), .PCF(PCF), .ValidF(ValidF),
    .StallV(StallV), .FlushV(FlushV), .BranchB(BranchB), .ZeroB(ZeroB),
    .PCTargetB(PCTargetB), .PCB(PCB), .BranchUpdB(BranchUpdB),
    .TakenB(TakenB), .MispredictB(MispredictB), .RedirectPC(RedirectPC),
    .BranchCnt(BranchCnt), .MissCnt(MissCnt)
  );

  bp_resolve_unit #(.DEPTH(DEPTH), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .BPF(BPF), .PCF(PCF), .ValidF(ValidF),
    .StallV(StallV), .FlushV(FlushV), .BranchB(BranchB), .ZeroB(ZeroB),
    .PCTargetB(PCTargetB), .PCB(s_PCB), .BranchUpdB(s_BranchUpdB),
    .TakenB(s_TakenB), .MispredictB(s_MispredictB),
    .RedirectPC(s_RedirectPC), .BranchCnt(s_BranchCnt), .MissCnt(s_MissCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        bp;
    logic        br;
    logic        z;
    logic [31:0] tgt;
    logic        flb;
  } txn_t;

  typedef struct {
    logic        upd;
    logic        tk;
    logic        mis;
    logic [31:0] red;
    logic [31:0] pc;
  } exp_t;

  txn_t stim[$];
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int unsigned m_b = 0, m_m = 0, m_b2 = 0, m_m2 = 0;

  function automatic exp_t model(input txn_t t);
    exp_t e;
    e.upd = t.br;
    e.tk  = t.br & t.z;
    e.mis = t.br ? (t.bp != t.z) : t.bp;
    e.red = !e.mis ? 32'd0 : (t.br && t.z) ? t.tgt : t.pc + 32'd4;
    e.pc  = t.pc;
    return e;
  endfunction

  task automatic idle();
    ValidF = 0; BPF = 0; PCF = 0;
    BranchB = 0; ZeroB = 0; PCTargetB = 0;
    StallV = '0; FlushV = '0;
  endtask

  task automatic model_step(input exp_t e);
    if (e.upd) begin
      if (m_b < 65535) m_b++;
      if (m_b2 < 3) m_b2++;
    end
    if (e.mis) begin
      if (m_m < 65535) m_m++;
      if (m_m2 < 3) m_m2++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1;
    @(negedge clk);
    reset = 0;
    sb.delete();
    m_b = 0; m_m = 0; m_b2 = 0; m_m2 = 0;
  endtask

  // Fetch stim[] back to back, resolve each at B, then drain.
  // Only the last entry may mispredict or carry a B flush.
  task automatic run_stream(input string tag);
    int   n;
    logic junk;
    exp_t e;
    txn_t t;
    n = stim.size();
    e = model(stim[n-1]);
    junk = e.mis;
    for (int c = 0; c < n + DEPTH; c++) begin
      @(negedge clk);
      if (c < n) begin
        ValidF = 1; BPF = stim[c].bp; PCF = stim[c].pc;
        sb.push_back(model(stim[c]));
      end else if (junk) begin
        ValidF = 1; BPF = 1; PCF = 32'hBAD0 + 32'(c * 4);
      end else begin
        ValidF = 0; BPF = 0; PCF = 0;
      end
      if (c >= DEPTH) begin
        t = stim[c-DEPTH];
        BranchB = t.br; ZeroB = t.z; PCTargetB = t.tgt;
        FlushV[DEPTH-1] = t.flb;
      end else begin
        BranchB = 0; ZeroB = 0; PCTargetB = 0; FlushV = '0;
      end
      #1;
      total += 2;
      if (BranchCnt !== 16'(m_b)) begin
        bad++;
        $display("FAIL %s BranchCnt got=%0d want=%0d", tag, BranchCnt, m_b);
      end
      if (s_MissCnt !== 2'(m_m2)) begin
        bad++;
        $display("FAIL %s MissCnt2 got=%0d want=%0d", tag, s_MissCnt, m_m2);
      end
      if (c >= DEPTH) begin
        e = sb.pop_front();
        total += 5;
        if (BranchUpdB !== e.upd) begin
          bad++;
          $display("FAIL %s BranchUpdB got=%b want=%b", tag, BranchUpdB, e.upd);
        end
        if (TakenB !== e.tk) begin
          bad++;
          $display("FAIL %s TakenB got=%b want=%b", tag, TakenB, e.tk);
        end
        if (MispredictB !== e.mis) begin
          bad++;
          $display("FAIL %s MispredictB got=%b want=%b", tag, MispredictB, e.mis);
        end
        if (RedirectPC !== e.red) begin
          bad++;
          $display("FAIL %s RedirectPC got=%h want=%h", tag, RedirectPC, e.red);
        end
        if (PCB !== e.pc) begin
          bad++;
          $display("FAIL %s PCB got=%h want=%h", tag, PCB, e.pc);
        end
        model_step(e);
      end
    end
    for (int d = 0; d <= DEPTH; d++) begin
      @(negedge clk);
      idle();
      #1;
      total += 4;
      if (MispredictB !== 1'b0 || BranchUpdB !== 1'b0) begin
        bad++;
        $display("FAIL %s drain%0d mis/upd got=%b%b want=00",
                 tag, d, MispredictB, BranchUpdB);
      end
      if (BranchCnt !== 16'(m_b)) begin
        bad++;
        $display("FAIL %s drain BranchCnt got=%0d want=%0d", tag, BranchCnt, m_b);
      end
      if (MissCnt !== 16'(m_m)) begin
        bad++;
        $display("FAIL %s drain MissCnt got=%0d want=%0d", tag, MissCnt, m_m);
      end
      if (s_BranchCnt !== 2'(m_b2)) begin
        bad++;
        $display("FAIL %s drain BranchCnt2 got=%0d want=%0d", tag, s_BranchCnt, m_b2);
      end
    end
    stim.delete();
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    ValidF = 1; BPF = 1; PCF = 32'h500;
    @(negedge clk);
    PCF = 32'h504;
    @(negedge clk);
    StallV = '1; ValidF = 0; reset = 1;
    #1;
    total++;
    if (PCB !== 32'h500) begin
      bad++;
      $display("FAIL reset_preload PCB got=%h want=%h", PCB, 32'h500);
    end
    @(negedge clk);
    reset = 0;
    idle();
    #1;
    total += 4;
    if (MispredictB !== 1'b0 || BranchUpdB !== 1'b0 || TakenB !== 1'b0) begin
      bad++;
      $display("FAIL reset_out mis/upd/tk got=%b%b%b want=000",
               MispredictB, BranchUpdB, TakenB);
    end
    if (PCB !== 32'd0 || RedirectPC !== 32'd0) begin
      bad++;
      $display("FAIL reset_pc PCB=%h RedirectPC=%h want=0", PCB, RedirectPC);
    end
    if (BranchCnt !== 16'd0 || MissCnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_cnt got=%0d/%0d want=0/0", BranchCnt, MissCnt);
    end
    if (s_BranchCnt !== 2'd0 || s_MissCnt !== 2'd0) begin
      bad++;
      $display("FAIL reset_cnt2 got=%0d/%0d want=0/0", s_BranchCnt, s_MissCnt);
    end
    @(negedge clk);
    #1;
    total++;
    if (MispredictB !== 1'b0) begin
      bad++;
      $display("FAIL reset_stage0 MispredictB got=%b want=0", MispredictB);
    end
    sb.delete();
  endtask

  task automatic test_taken_hit();
    stim.push_back('{pc:32'h100, bp:1'b1, br:1'b1, z:1'b1, tgt:32'h180, flb:1'b0});
    run_stream("taken_hit");
    total++;
    if (BranchCnt !== 16'd1) begin
      bad++;
      $display("FAIL taken_hit_cnt BranchCnt got=%0d want=1", BranchCnt);
    end
  endtask

  task automatic test_mispredict_taken();
    stim.push_back('{pc:32'h200, bp:1'b0, br:1'b1, z:1'b1, tgt:32'h240, flb:1'b0});
    run_stream("miss_taken");
    total++;
    if (MissCnt !== 16'd1) begin
      bad++;
      $display("FAIL miss_taken_cnt MissCnt got=%0d want=1", MissCnt);
    end
  endtask

  task automatic test_nonbranch();
    stim.push_back('{pc:32'h300, bp:1'b1, br:1'b0, z:1'b0, tgt:32'h999, flb:1'b0});
    run_stream("nonbranch");
  endtask

  task automatic test_wrap();
    stim.push_back('{pc:32'hFFFF_FFFC, bp:1'b1, br:1'b1, z:1'b0, tgt:32'h50, flb:1'b0});
    run_stream("wrap");
  endtask

  task automatic test_stall();
    txn_t t;
    exp_t e;
    t = '{pc:32'h400, bp:1'b0, br:1'b1, z:1'b0, tgt:32'h480, flb:1'b0};
    @(negedge clk);
    ValidF = 1; BPF = t.bp; PCF = t.pc;
    sb.push_back(model(t));
    repeat (DEPTH) begin
      @(negedge clk);
      idle();
    end
    for (int h = 0; h < 3; h++) begin
      if (h > 0) @(negedge clk);
      StallV = '1; BranchB = 1; ZeroB = 0; PCTargetB = t.tgt;
      #1;
      total += 2;
      if (BranchUpdB !== 1'b0 || MispredictB !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold%0d upd/mis got=%b%b want=00", h, BranchUpdB, MispredictB);
      end
      if (BranchCnt !== 16'(m_b)) begin
        bad++;
        $display("FAIL stall_hold_cnt got=%0d want=%0d", BranchCnt, m_b);
      end
    end
    @(negedge clk);
    StallV = '0;
    #1;
    e = sb.pop_front();
    total += 2;
    if (BranchUpdB !== e.upd || MispredictB !== e.mis) begin
      bad++;
      $display("FAIL stall_release upd/mis got=%b%b want=%b%b",
               BranchUpdB, MispredictB, e.upd, e.mis);
    end
    if (PCB !== e.pc) begin
      bad++;
      $display("FAIL stall_release PCB got=%h want=%h", PCB, e.pc);
    end
    model_step(e);
    @(negedge clk);
    #1;
    total += 2;
    if (BranchUpdB !== 1'b0) begin
      bad++;
      $display("FAIL stall_once BranchUpdB got=%b want=0", BranchUpdB);
    end
    if (BranchCnt !== 16'(m_b)) begin
      bad++;
      $display("FAIL stall_cnt BranchCnt got=%0d want=%0d", BranchCnt, m_b);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    txn_t t;
    for (int i = 0; i < 8; i++) begin
      t.pc  = $urandom() & 32'hFFFF_FFFC;
      t.br  = 1'($urandom_range(0, 1));
      t.z   = 1'($urandom_range(0, 1));
      t.bp  = t.br ? t.z : 1'b0;
      t.tgt = $urandom() & 32'hFFFF_FFFC;
      t.flb = 1'b0;
      stim.push_back(t);
    end
    run_stream("b2b");
  endtask

  task automatic test_flush_fire();
    stim.push_back('{pc:32'h700, bp:1'b0, br:1'b1, z:1'b1, tgt:32'h780, flb:1'b1});
    run_stream("flush_fire");
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      stim.push_back('{pc:32'h600 + 32'(i * 8), bp:1'b1, br:1'b0, z:1'b0,
                       tgt:32'h0, flb:1'b0});
      run_stream("saturate");
    end
    total += 2;
    if (s_MissCnt !== 2'd3) begin
      bad++;
      $display("FAIL sat_cnt2 MissCnt got=%0d want=3", s_MissCnt);
    end
    if (MissCnt !== 16'd5) begin
      bad++;
      $display("FAIL sat_cnt16 MissCnt got=%0d want=5", MissCnt);
    end
  endtask

  initial begin
    test_reset();
    test_taken_hit();
    test_mispredict_taken();
    test_nonbranch();
    test_wrap();
    test_stall();
    test_back_to_back();
    test_flush_fire();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
